rom_bus_ctrl: RTL and testbench

Bus-cycle sequencer that sits between the 8085 multiplexed bus and the 8775-style ROM peripheral. It demultiplexes the low address from AD on ALE and decodes the ROM region from the high address byte. It drives the ROM's chip select and read enable, and inserts a programmable number of wait states by pulling READY low. It flags any write cycle aimed at the ROM region.

---
 rtl/rom_bus_ctrl.sv | 103 ++++++++++
 tb/tb_rom_bus_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rom_bus_ctrl.sv
// Bus-cycle sequencer between an 8085 multiplexed bus and an 8775-style ROM:
// latches the low address on ALE, decodes the ROM region, drives CSn/OEn and inserts READY wait states.
module rom_bus_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  BASE        = 8'h00,
  parameter logic [7:0]  MASK        = 8'hF8
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [7:0] AD,
  input  logic [7:0] A_HI,
  input  logic       ALE,
  input  logic       RDn,
  input  logic       WRn,
  input  logic       IO_Mn,
  output logic [7:0] ADD,
  output logic       CSn,
  output logic       OEn,
  output logic       READY,
  output logic       WR_ERR
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] add_d;
  logic       wr_err_d;
  logic       hit;

  assign hit = ~IO_Mn & ((A_HI & MASK) == (BASE & MASK));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    add_d    = ADD;
    wr_err_d = 1'b0;
    if (ALE) begin
      // ALE abandons whatever cycle was in progress
      add_d   = AD;
      state_d = hit ? S_ADDR : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR: begin
          if (!RDn) begin
            if (WS == 4'd0) begin
              state_d = S_DATA;
            end else begin
              state_d = S_WAIT;
              wcnt_d  = WS;
            end
          end else if (!WRn) begin
            wr_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_WAIT: begin
          if (RDn) begin
            state_d = S_IDLE;
          end else if (wcnt_q == 4'd1) begin
            state_d = S_DATA;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
        S_DATA: begin
          if (RDn) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ADD     <= '0;
      CSn     <= 1'b1;
      OEn     <= 1'b1;
      READY   <= 1'b1;
      WR_ERR  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ADD     <= add_d;
      CSn     <= (state_d == S_IDLE);
      OEn     <= ~((state_d == S_WAIT) || (state_d == S_DATA));
      READY   <= (state_d != S_WAIT);
      WR_ERR  <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Directed bench for rom_bus_ctrl: four instances with different wait-state counts share the bus;
// each step queues the expected outputs of the selected instance and checks them after the edge.
module tb_rom_bus_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] ad, a_hi;
  logic       ale, rdn, wrn, iom;

  logic [7:0] add_o [4];
  logic [3:0] csn, oen, rdy, werr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] add;
    logic       csn, oen, rdy, werr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rom_bus_ctrl #(.WAIT_STATES(1)) u_ws1 (
    .CLK(clk), .RESETn(rstn), .AD(ad), .A_HI(a_hi), .ALE(ale), .RDn(rdn), .WRn(wrn),
    .IO_Mn(iom), .ADD(add_o[0]), .CSn(csn[0]), .OEn(oen[0]), .READY(rdy[0]), .WR_ERR(werr[0]));

  rom_bus_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RESETn(rstn), .AD(ad), .A_HI(a_hi), .ALE(ale), .RDn(rdn), .WRn(wrn),
    .IO_Mn(iom), .ADD(add_o[1]), .CSn(csn[1]), .OEn(oen[1]), .READY(rdy[1]), .WR_ERR(werr[1]));

  rom_bus_ctrl #(.WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RESETn(rstn), .AD(ad), .A_HI(a_hi), .ALE(ale), .RDn(rdn), .WRn(wrn),
    .IO_Mn(iom), .ADD(add_o[2]), .CSn(csn[2]), .OEn(oen[2]), .READY(rdy[2]), .WR_ERR(werr[2]));

  rom_bus_ctrl #(.WAIT_STATES(4)) u_ws4 (
    .CLK(clk), .RESETn(rstn), .AD(ad), .A_HI(a_hi), .ALE(ale), .RDn(rdn), .WRn(wrn),
    .IO_Mn(iom), .ADD(add_o[3]), .CSn(csn[3]), .OEn(oen[3]), .READY(rdy[3]), .WR_ERR(werr[3]));

  // Drive one cycle of bus inputs, queue expectations, then compare just after the edge
  task automatic step(input string tag, input int sel, input logic r, input logic al,
                      input logic rd, input logic wr, input logic io,
                      input logic [7:0] d, input logic [7:0] hi,
                      input logic [7:0] e_add, input logic e_csn, input logic e_oen,
                      input logic e_rdy, input logic e_werr);
    exp_t e;
    rstn = r; ale = al; rdn = rd; wrn = wr; iom = io; ad = d; a_hi = hi;
    sb.push_back('{tag, sel, e_add, e_csn, e_oen, e_rdy, e_werr});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (add_o[e.sel] === e.add) else begin
      failures++;
      $error("FAIL %s ADD obs=%0h exp=%0h", e.tag, add_o[e.sel], e.add);
    end
    checks++;
    assert (csn[e.sel] === e.csn) else begin
      failures++;
      $error("FAIL %s CSn obs=%0b exp=%0b", e.tag, csn[e.sel], e.csn);
    end
    checks++;
    assert (oen[e.sel] === e.oen) else begin
      failures++;
      $error("FAIL %s OEn obs=%0b exp=%0b", e.tag, oen[e.sel], e.oen);
    end
    checks++;
    assert (rdy[e.sel] === e.rdy) else begin
      failures++;
      $error("FAIL %s READY obs=%0b exp=%0b", e.tag, rdy[e.sel], e.rdy);
    end
    checks++;
    assert (werr[e.sel] === e.werr) else begin
      failures++;
      $error("FAIL %s WR_ERR obs=%0b exp=%0b", e.tag, werr[e.sel], e.werr);
    end
  endtask

  initial begin
    rstn = 1'b0; ale = 1'b0; rdn = 1'b1; wrn = 1'b1; iom = 1'b0; ad = '0; a_hi = '0;
    #1;
    // tag            sel rst ale rd wr io  AD     A_HI    ADD   CS OE RDY WE
    step("rst0",       0, 0,  1,  0, 1, 0, 8'h5A, 8'h03, 8'h00, 1, 1, 1, 0);
    step("rst1",       0, 0,  1,  0, 1, 0, 8'h5A, 8'h03, 8'h00, 1, 1, 1, 0);
    step("rst_ws3",    1, 0,  0,  1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 0);

    // hit read, one wait state
    step("hit_ale",    0, 1,  1,  1, 1, 0, 8'h5A, 8'h03, 8'h5A, 0, 1, 1, 0);
    step("hit_wait",   0, 1,  0,  0, 1, 0, 8'hC3, 8'h03, 8'h5A, 0, 0, 0, 0);
    step("hit_data1",  0, 1,  0,  0, 1, 0, 8'hC3, 8'h03, 8'h5A, 0, 0, 1, 0);
    step("hit_data2",  0, 1,  0,  0, 1, 0, 8'hC3, 8'h03, 8'h5A, 0, 0, 1, 0);
    step("hit_data3",  0, 1,  0,  0, 1, 0, 8'hC3, 8'h03, 8'h5A, 0, 0, 1, 0);
    step("hit_end",    0, 1,  0,  1, 1, 0, 8'hC3, 8'h03, 8'h5A, 1, 1, 1, 0);

    // miss: out of region, then an I/O cycle in region
    step("miss_ale",   0, 1,  1,  1, 1, 0, 8'h11, 8'h08, 8'h11, 1, 1, 1, 0);
    step("miss_rd0",   0, 1,  0,  0, 1, 0, 8'h00, 8'h08, 8'h11, 1, 1, 1, 0);
    step("miss_rd1",   0, 1,  0,  0, 1, 0, 8'h00, 8'h08, 8'h11, 1, 1, 1, 0);
    step("miss_end",   0, 1,  0,  1, 1, 0, 8'h00, 8'h08, 8'h11, 1, 1, 1, 0);
    step("io_ale",     0, 1,  1,  1, 1, 1, 8'h22, 8'h00, 8'h22, 1, 1, 1, 0);
    step("io_rd0",     0, 1,  0,  0, 1, 1, 8'h00, 8'h00, 8'h22, 1, 1, 1, 0);
    step("io_rd1",     0, 1,  0,  0, 1, 1, 8'h00, 8'h00, 8'h22, 1, 1, 1, 0);
    step("io_end",     0, 1,  0,  1, 1, 1, 8'h00, 8'h00, 8'h22, 1, 1, 1, 0);

    // three wait states
    step("ws3_ale",    1, 1,  1,  1, 1, 0, 8'h33, 8'h03, 8'h33, 0, 1, 1, 0);
    step("ws3_w1",     1, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h33, 0, 0, 0, 0);
    step("ws3_w2",     1, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h33, 0, 0, 0, 0);
    step("ws3_w3",     1, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h33, 0, 0, 0, 0);
    step("ws3_data",   1, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h33, 0, 0, 1, 0);
    step("ws3_end",    1, 1,  0,  1, 1, 0, 8'h00, 8'h03, 8'h33, 1, 1, 1, 0);

    // zero wait states
    step("ws0_ale",    2, 1,  1,  1, 1, 0, 8'h3C, 8'h07, 8'h3C, 0, 1, 1, 0);
    step("ws0_data1",  2, 1,  0,  0, 1, 0, 8'h00, 8'h07, 8'h3C, 0, 0, 1, 0);
    step("ws0_data2",  2, 1,  0,  0, 1, 0, 8'h00, 8'h07, 8'h3C, 0, 0, 1, 0);
    step("ws0_end",    2, 1,  0,  1, 1, 0, 8'h00, 8'h07, 8'h3C, 1, 1, 1, 0);

    // RDn and WRn low together is a read
    step("rw_ale",     2, 1,  1,  1, 1, 0, 8'h3D, 8'h00, 8'h3D, 0, 1, 1, 0);
    step("rw_both",    2, 1,  0,  0, 0, 0, 8'h00, 8'h00, 8'h3D, 0, 0, 1, 0);
    step("rw_end",     2, 1,  0,  1, 1, 0, 8'h00, 8'h00, 8'h3D, 1, 1, 1, 0);

    // write into ROM region
    step("wr_ale",     0, 1,  1,  1, 1, 0, 8'h44, 8'h00, 8'h44, 0, 1, 1, 0);
    step("wr_err",     0, 1,  0,  1, 0, 0, 8'h00, 8'h00, 8'h44, 1, 1, 1, 1);
    step("wr_clr",     0, 1,  0,  1, 1, 0, 8'h00, 8'h00, 8'h44, 1, 1, 1, 0);

    // aborts with four wait states: RDn rises during WAIT
    step("ab_ale",     3, 1,  1,  1, 1, 0, 8'h55, 8'h03, 8'h55, 0, 1, 1, 0);
    step("ab_w1",      3, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h55, 0, 0, 0, 0);
    step("ab_w2",      3, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h55, 0, 0, 0, 0);
    step("ab_rdhi",    3, 1,  0,  1, 1, 0, 8'h00, 8'h03, 8'h55, 1, 1, 1, 0);

    // ALE to a miss address during WAIT
    step("ab2_ale",    3, 1,  1,  1, 1, 0, 8'h66, 8'h03, 8'h66, 0, 1, 1, 0);
    step("ab2_w1",     3, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h66, 0, 0, 0, 0);
    step("ab2_w2",     3, 1,  0,  0, 1, 0, 8'h00, 8'h03, 8'h66, 0, 0, 0, 0);
    step("ab2_miss",   3, 1,  1,  0, 1, 0, 8'h77, 8'h10, 8'h77, 1, 1, 1, 0);
    step("ab2_hold",   3, 1,  0,  1, 1, 0, 8'h00, 8'h10, 8'h77, 1, 1, 1, 0);

    // reset in the middle of a wait sequence
    step("mr_ale",     1, 1,  1,  1, 1, 0, 8'h88, 8'h01, 8'h88, 0, 1, 1, 0);
    step("mr_w1",      1, 1,  0,  0, 1, 0, 8'h00, 8'h01, 8'h88, 0, 0, 0, 0);
    step("mr_rst",     1, 0,  0,  0, 1, 0, 8'h00, 8'h01, 8'h00, 1, 1, 1, 0);
    step("mr_after",   1, 1,  0,  0, 1, 0, 8'h00, 8'h01, 8'h00, 1, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
